// File: rtl/eth_pkt_gen_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkt_gen_pkg
// Shared definitions for the Ethernet test-packet generator:
//   - FSM state encodings (IDLE, SEND, GAP, END)
//   - Ethernet / VLAN header constants and the effective header length
//   - latched header configuration struct
//   - hdr_byte(): returns header byte n of a frame built from that config
// Optional feature macro: ETH_PKT_GEN_VLAN_EN (adds the 802.1Q tag, H = 18).
// -----------------------------------------------------------------------------
package eth_pkt_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_END  = 2'd3;

   localparam int          ETH_HDR_BYTES  = 14;
   localparam int          VLAN_TAG_BYTES = 4;
   localparam logic [15:0] VLAN_TPID      = 16'h8100;

`ifdef ETH_PKT_GEN_VLAN_EN
   localparam int HDR_LEN = ETH_HDR_BYTES + VLAN_TAG_BYTES;
`else
   localparam int HDR_LEN = ETH_HDR_BYTES;
`endif

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
`ifdef ETH_PKT_GEN_VLAN_EN
      logic [11:0] vid;
      logic [2:0]  pri;
`endif
      logic [15:0] eth_type;
      logic [7:0]  seed;
   } hdr_cfg_t;

   // Header byte n (0 = first byte on the wire); n >= HDR_LEN returns 0.
   function automatic logic [7:0] hdr_byte(input hdr_cfg_t cfg, input logic [4:0] n);
      logic [7:0] b;
      b = 8'h00;
      case (n)
         5'd0:  b = cfg.dst[47:40];
         5'd1:  b = cfg.dst[39:32];
         5'd2:  b = cfg.dst[31:24];
         5'd3:  b = cfg.dst[23:16];
         5'd4:  b = cfg.dst[15:8];
         5'd5:  b = cfg.dst[7:0];
         5'd6:  b = cfg.src[47:40];
         5'd7:  b = cfg.src[39:32];
         5'd8:  b = cfg.src[31:24];
         5'd9:  b = cfg.src[23:16];
         5'd10: b = cfg.src[15:8];
         5'd11: b = cfg.src[7:0];
`ifdef ETH_PKT_GEN_VLAN_EN
         5'd12: b = VLAN_TPID[15:8];
         5'd13: b = VLAN_TPID[7:0];
         5'd14: b = {cfg.pri, 1'b0, cfg.vid[11:8]};
         5'd15: b = cfg.vid[7:0];
         5'd16: b = cfg.eth_type[15:8];
         5'd17: b = cfg.eth_type[7:0];
`else
         5'd12: b = cfg.eth_type[15:8];
         5'd13: b = cfg.eth_type[7:0];
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/eth_pkt_gen_beat.sv
// -----------------------------------------------------------------------------
// eth_pkt_gen_beat
// Combinational beat builder. For the beat that starts at frame byte Offset it
// produces the data bytes (byte 0 in the MSB lane) and MSB-contiguous byte
// enables. Bytes at or beyond Total are zero with their enable cleared.
// Ports:
//   Offset   in  17      frame byte index of lane 0
//   Cfg      in  struct  latched header configuration
//   Total    in  17      frame length in bytes (header + payload)
//   BeatData out DATA_W  beat data, network order
//   BeatKeep out DATA_W/8 byte enables, MSB = lane 0
// Optional feature macro: ETH_PKT_GEN_VLAN_EN (through the package header length).
// -----------------------------------------------------------------------------
module eth_pkt_gen_beat
   import eth_pkt_gen_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [16:0]         Offset,
   input  hdr_cfg_t            Cfg,
   input  logic [16:0]         Total,
   output logic [DATA_W-1:0]   BeatData,
   output logic [DATA_W/8-1:0] BeatKeep
);

   localparam int BYTES = DATA_W / 8;

   for (genvar j = 0; j < BYTES; j++) begin : g_lane
      logic [16:0] pos;
      logic        in_frame;
      logic [7:0]  byte_val;

      assign pos      = Offset + 17'(j);
      assign in_frame = pos < Total;
      // Payload byte k = seed + k; only the low 8 bits of pos matter mod 256.
      assign byte_val = (pos < 17'(HDR_LEN)) ? hdr_byte(Cfg, pos[4:0])
                                             : Cfg.seed + (pos[7:0] - 8'(HDR_LEN));

      assign BeatKeep[BYTES-1-j]         = in_frame;
      assign BeatData[DATA_W-1-8*j -: 8] = in_frame ? byte_val : 8'h00;
   end

endmodule

// File: rtl/eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// eth_pkt_gen
// In-fabric Ethernet test-packet generator with payload-length sweep,
// inter-packet gap, graceful stop and AXI-stream style backpressure.
// Ports:
//   SysClk, Rst            clock, asynchronous active-high reset
//   Start, Stop            run control pulses (Start latches all Cfg*)
//   Cfg*                   header fields, length sweep, packet count, gap, seed
//                          (CfgVlanId / CfgVlanPri only with ETH_PKT_GEN_VLAN_EN)
//   TxReady                sink ready
//   TxValid/Sop/Eop/Data/Keep  output stream
//   Busy, Done, PktCnt     run status
//   DbgState               current FSM state (debug visibility)
// Optional feature macro: ETH_PKT_GEN_VLAN_EN (802.1Q tag on every frame).
// -----------------------------------------------------------------------------
module eth_pkt_gen
   import eth_pkt_gen_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MAX_LEN = 9000,
   parameter int CNT_W   = 32
)(
   input  logic                SysClk,
   input  logic                Rst,
   input  logic                Start,
   input  logic                Stop,
   input  logic [47:0]         CfgDstMac,
   input  logic [47:0]         CfgSrcMac,
`ifdef ETH_PKT_GEN_VLAN_EN
   input  logic [11:0]         CfgVlanId,
   input  logic [2:0]          CfgVlanPri,
`endif
   input  logic [15:0]         CfgEthType,
   input  logic [15:0]         CfgPayLen,
   input  logic [15:0]         CfgLenStep,
   input  logic [15:0]         CfgPktNum,
   input  logic [15:0]         CfgGap,
   input  logic [7:0]          CfgSeed,
   input  logic                TxReady,
   output logic                TxValid,
   output logic                TxSop,
   output logic                TxEop,
   output logic [DATA_W-1:0]   TxData,
   output logic [DATA_W/8-1:0] TxKeep,
   output logic                Busy,
   output logic                Done,
   output logic [CNT_W-1:0]    PktCnt,
   output logic [1:0]          DbgState
);

   localparam int BYTES = DATA_W / 8;

   logic [1:0]          state;
   hdr_cfg_t            cfg;
   logic [15:0]         pay_len;
   logic [15:0]         len_base;
   logic [15:0]         len_step;
   logic [15:0]         pkt_num;
   logic [15:0]         gap;
   logic [15:0]         gap_cnt;
   logic [16:0]         offset;
   logic [16:0]         total;
   logic [16:0]         len_sum;
   logic                stop_pend;
   logic                hs;
   logic                last_beat;
   logic                run_end;
   logic [CNT_W-1:0]    cnt_inc;
   logic [DATA_W-1:0]   beat_data;
   logic [BYTES-1:0]    beat_keep;

   // Handshake: a beat transfers on a rising SysClk edge where TxValid and
   // TxReady are both high. TxValid is decoded from registered state only, and
   // offset/config change only on a transfer, so data and qualifiers hold
   // stable while TxReady is low.
   assign TxValid   = (state == ST_SEND);
   assign hs        = TxValid && TxReady;
   assign total     = 17'(HDR_LEN) + {1'b0, pay_len};
   assign last_beat = (offset + 17'(BYTES)) >= total;
   assign TxSop     = TxValid && (offset == 17'd0);
   assign TxEop     = TxValid && last_beat;
   assign TxData    = TxValid ? beat_data : '0;
   assign TxKeep    = TxValid ? beat_keep : '0;
   assign Busy      = (state == ST_SEND) || (state == ST_GAP);
   assign Done      = (state == ST_END);
   assign DbgState  = state;

   assign cnt_inc   = PktCnt + CNT_W'(1);
   // PktNum == 0 runs until stopped.
   assign run_end   = (pkt_num != 16'd0) && (cnt_inc == CNT_W'(pkt_num));
   assign len_sum   = {1'b0, pay_len} + {1'b0, len_step};

   eth_pkt_gen_beat #(.DATA_W(DATA_W)) u_beat (
      .Offset   (offset),
      .Cfg      (cfg),
      .Total    (total),
      .BeatData (beat_data),
      .BeatKeep (beat_keep)
   );

   always_ff @(posedge SysClk or posedge Rst) begin
      if (Rst) begin
         state     <= ST_IDLE;
         cfg       <= '0;
         pay_len   <= '0;
         len_base  <= '0;
         len_step  <= '0;
         pkt_num   <= '0;
         gap       <= '0;
         gap_cnt   <= '0;
         offset    <= '0;
         stop_pend <= 1'b0;
         PktCnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Stop wins over a simultaneous Start.
               if (Start && !Stop) begin
                  state        <= ST_SEND;
                  cfg.dst      <= CfgDstMac;
                  cfg.src      <= CfgSrcMac;
`ifdef ETH_PKT_GEN_VLAN_EN
                  cfg.vid      <= CfgVlanId;
                  cfg.pri      <= CfgVlanPri;
`endif
                  cfg.eth_type <= CfgEthType;
                  cfg.seed     <= CfgSeed;
                  pay_len      <= (CfgPayLen == 16'd0) ? 16'd1 : CfgPayLen;
                  len_base     <= (CfgPayLen == 16'd0) ? 16'd1 : CfgPayLen;
                  len_step     <= CfgLenStep;
                  pkt_num      <= CfgPktNum;
                  gap          <= CfgGap;
                  offset       <= '0;
                  stop_pend    <= 1'b0;
                  PktCnt       <= '0;
               end
            end
            ST_SEND: begin
               if (Stop) stop_pend <= 1'b1;
               if (hs) begin
                  if (last_beat) begin
                     offset  <= '0;
                     PktCnt  <= cnt_inc;
                     pay_len <= (len_sum > 17'(MAX_LEN)) ? len_base : len_sum[15:0];
                     if (run_end || stop_pend || Stop) begin
                        state <= ST_END;
                     end else if (gap != 16'd0) begin
                        state   <= ST_GAP;
                        gap_cnt <= gap;
                     end
                  end else begin
                     offset <= offset + 17'(BYTES);
                  end
               end
            end
            ST_GAP: begin
               if (Stop) begin
                  state <= ST_END;
               end else if (gap_cnt == 16'd1) begin
                  state <= ST_SEND;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            ST_END:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_eth_pkt_gen
// Directed bench for eth_pkt_gen (DATA_W = 32, MAX_LEN = 100). Expected beats
// and inter-packet gaps are queued when a run is issued; a monitor process pops
// and compares each accepted beat, checks hold-during-stall, gap lengths and
// Done timing. Follows ETH_PKT_GEN_VLAN_EN for header layout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_pkt_gen;

   localparam int DATA_W  = 32;
   localparam int BYTES   = DATA_W / 8;
   localparam int MAX_LEN = 100;
   localparam int CNT_W   = 32;
   localparam int W       = 2 + BYTES + DATA_W;

   logic              SysClk = 1'b0;
   logic              Rst = 1'b1;
   logic              Start = 1'b0;
   logic              Stop = 1'b0;
   logic [47:0]       CfgDstMac = '0;
   logic [47:0]       CfgSrcMac = '0;
`ifdef ETH_PKT_GEN_VLAN_EN
   logic [11:0]       CfgVlanId = '0;
   logic [2:0]        CfgVlanPri = '0;
`endif
   logic [15:0]       CfgEthType = '0;
   logic [15:0]       CfgPayLen = '0;
   logic [15:0]       CfgLenStep = '0;
   logic [15:0]       CfgPktNum = '0;
   logic [15:0]       CfgGap = '0;
   logic [7:0]        CfgSeed = '0;
   logic              TxReady = 1'b1;
   logic              TxValid, TxSop, TxEop;
   logic [DATA_W-1:0] TxData;
   logic [BYTES-1:0]  TxKeep;
   logic              Busy, Done;
   logic [CNT_W-1:0]  PktCnt;
   logic [1:0]        DbgState;

   eth_pkt_gen #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .SysClk(SysClk), .Rst(Rst), .Start(Start), .Stop(Stop),
      .CfgDstMac(CfgDstMac), .CfgSrcMac(CfgSrcMac),
`ifdef ETH_PKT_GEN_VLAN_EN
      .CfgVlanId(CfgVlanId), .CfgVlanPri(CfgVlanPri),
`endif
      .CfgEthType(CfgEthType), .CfgPayLen(CfgPayLen), .CfgLenStep(CfgLenStep),
      .CfgPktNum(CfgPktNum), .CfgGap(CfgGap), .CfgSeed(CfgSeed),
      .TxReady(TxReady), .TxValid(TxValid), .TxSop(TxSop), .TxEop(TxEop),
      .TxData(TxData), .TxKeep(TxKeep), .Busy(Busy), .Done(Done),
      .PktCnt(PktCnt), .DbgState(DbgState)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 SysClk = ~SysClk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           gap_q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   bit           rand_ready = 0;
   int           pkts_acc = 0;
   int           beat_idx = 0;
   int           last_pkt_beats = 0;
   logic [3:0]   last_keep = '0;
   logic [31:0]  cur_pkt[$];

   logic [47:0]  t_dst, t_src;
   logic [11:0]  t_vid;
   logic [2:0]   t_pri;
   logic [15:0]  t_et;
   logic [7:0]   t_seed;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Ready driver: changes only just after the active edge.
   initial forever begin
      @(posedge SysClk); #1;
      TxReady = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // ---------------- expected-frame builder ----------------
   task automatic push_pkt(input int len);
      logic [7:0]   fb[$];
      logic [W-1:0] e;
      int           total, nb;
      for (int i = 5; i >= 0; i--) fb.push_back(t_dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(t_src[8*i +: 8]);
`ifdef ETH_PKT_GEN_VLAN_EN
      fb.push_back(8'h81); fb.push_back(8'h00);
      fb.push_back({t_pri, 1'b0, t_vid[11:8]}); fb.push_back(t_vid[7:0]);
`endif
      fb.push_back(t_et[15:8]); fb.push_back(t_et[7:0]);
      for (int k = 0; k < len; k++) fb.push_back(8'(int'(t_seed) + k));
      total = fb.size();
      nb = (total + BYTES - 1) / BYTES;
      for (int b = 0; b < nb; b++) begin
         e = '0;
         e[W-1] = (b == 0);
         e[W-2] = (b == nb - 1);
         for (int j = 0; j < BYTES; j++) begin
            if (b * BYTES + j < total) begin
               e[DATA_W + BYTES - 1 - j] = 1'b1;
               e[DATA_W - 1 - 8*j -: 8] = fb[b * BYTES + j];
            end
         end
         exp_q.push_back(e);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic scramble_cfg();
      CfgDstMac  = {16'($urandom()), 32'($urandom())};
      CfgSrcMac  = {16'($urandom()), 32'($urandom())};
`ifdef ETH_PKT_GEN_VLAN_EN
      CfgVlanId  = 12'($urandom());
      CfgVlanPri = 3'($urandom());
`endif
      CfgEthType = 16'($urandom());
      CfgPayLen  = 16'($urandom_range(0, 65535));
      CfgLenStep = 16'($urandom_range(0, 65535));
      CfgPktNum  = 16'($urandom_range(0, 65535));
      CfgGap     = 16'($urandom_range(0, 65535));
      CfgSeed    = 8'($urandom());
   endtask

   // Queue expectations for n_exp packets, then pulse Start with the config.
   task automatic run_cfg(input int pay, input int step, input int num, input int gap, input int n_exp);
      int l, base, nl;
      l = (pay == 0) ? 1 : pay;
      base = l;
      for (int i = 0; i < n_exp; i++) begin
         push_pkt(l);
         if (i > 0) gap_q.push_back(gap);
         nl = l + step;
         if (nl > MAX_LEN) nl = base;
         l = nl;
      end
      pkts_acc = 0;
      beat_idx = 0;
      @(posedge SysClk); #1;
      CfgDstMac = t_dst; CfgSrcMac = t_src;
`ifdef ETH_PKT_GEN_VLAN_EN
      CfgVlanId = t_vid; CfgVlanPri = t_pri;
`endif
      CfgEthType = t_et; CfgSeed = t_seed;
      CfgPayLen = 16'(pay); CfgLenStep = 16'(step);
      CfgPktNum = 16'(num); CfgGap = 16'(gap);
      Start = 1'b1;
      @(posedge SysClk); #1;
      Start = 1'b0;
      check(TxValid && TxSop, "start_latency", {62'd0, TxValid, TxSop}, 64'h3);
      scramble_cfg();
   endtask

   task automatic wait_done(input int budget, input string name);
      int c;
      c = 0;
      do begin
         @(negedge SysClk);
         c++;
      end while (!Done && c < budget);
      check(Done, {name, "_done_timeout"}, 64'(c), 64'(budget));
      @(negedge SysClk);
   endtask

   task automatic wait_beat(input int pk, input int bi, input string name);
      int c;
      c = 0;
      while (!(pkts_acc == pk && beat_idx == bi) && c < 1000) begin
         @(negedge SysClk);
         c++;
      end
      check(pkts_acc == pk && beat_idx == bi, name, 64'(c), 64'd1000);
   endtask

   task automatic end_checks(input string name, input int cnt);
      check(exp_q.size() == 0, {name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
      check(gap_q.size() == 0, {name, "_gaps_left"}, 64'(gap_q.size()), 64'd0);
      check(PktCnt == CNT_W'(cnt), {name, "_pktcnt"}, 64'(PktCnt), 64'(cnt));
      check(!Busy && !Done && !TxValid, {name, "_idle"}, {61'd0, Busy, Done, TxValid}, 64'd0);
   endtask

   // ---------------- monitor ----------------
   logic [W-1:0] act_beat, prev_beat, e_beat;
   bit           prev_stall = 0;
   bit           prev_eop_hs = 0;
   bit           prev_done = 0;
   bit           seen_eop = 0;
   int           idle_cyc = 0;
   int           g_exp;

   initial forever begin
      @(negedge SysClk);
      if (Rst) begin
         prev_stall = 0; prev_eop_hs = 0; prev_done = 0; seen_eop = 0;
         idle_cyc = 0; beat_idx = 0;
      end else begin
         act_beat = {TxSop, TxEop, TxKeep, TxData};
         if (prev_stall)
            check(TxValid && act_beat == prev_beat, "stall_hold", 64'(act_beat), 64'(prev_beat));
         if (Done) check(prev_eop_hs && !Busy, "done_after_eop", {62'd0, prev_eop_hs, Busy}, 64'h2);
         if (prev_done) check(!Done, "done_one_cycle", 64'(Done), 64'd0);
         if (seen_eop && !(TxValid && TxReady && TxEop)) begin
            if (!TxValid) idle_cyc++;
            else if (TxSop) begin
               if (gap_q.size() == 0) check(0, "gap_unexpected_sop", 64'(idle_cyc), 64'd0);
               else begin
                  g_exp = gap_q.pop_front();
                  check(idle_cyc == g_exp, "gap_len", 64'(idle_cyc), 64'(g_exp));
               end
               seen_eop = 0;
            end
         end
         if (TxValid && TxReady) begin
            if (exp_q.size() == 0) check(0, "unexpected_beat", 64'(act_beat), 64'd0);
            else begin
               e_beat = exp_q.pop_front();
               check(act_beat == e_beat, "beat", 64'(act_beat), 64'(e_beat));
            end
            if (TxSop) begin cur_pkt.delete(); beat_idx = 0; end
            cur_pkt.push_back(TxData);
            beat_idx++;
            if (TxEop) begin
               pkts_acc++;
               last_pkt_beats = beat_idx;
               last_keep = TxKeep;
               beat_idx = 0;
               seen_eop = 1;
               idle_cyc = 0;
            end
         end
         if (Done) seen_eop = 0;
         prev_eop_hs = TxValid && TxReady && TxEop;
         prev_stall  = TxValid && !TxReady;
         prev_beat   = act_beat;
         prev_done   = Done;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int c;
      bit any_valid;
      t_dst = 48'haabbccddeeff; t_src = 48'h112233445566;
      t_vid = 12'h101; t_pri = 3'd0; t_et = 16'h0800; t_seed = 8'ha0;

      // Reset values
      repeat (3) @(negedge SysClk);
      check({TxValid, TxSop, TxEop, Busy, Done} == 5'd0, "rst_ctrl", 64'({TxValid, TxSop, TxEop, Busy, Done}), 64'd0);
      check(TxData == '0 && TxKeep == '0, "rst_data", 64'({TxKeep, TxData}), 64'd0);
      check(PktCnt == '0 && DbgState == 2'd0, "rst_cnt_state", 64'({PktCnt, DbgState}), 64'd0);
      @(posedge SysClk); #1 Rst = 1'b0;

      // Single VLAN-style packet, 51-byte payload
      run_cfg(51, 0, 1, 0, 1);
      wait_done(400, "single");
      end_checks("single", 1);
`ifdef ETH_PKT_GEN_VLAN_EN
      check(last_pkt_beats == 18, "single_nbeats", 64'(last_pkt_beats), 64'd18);
      check(cur_pkt[3] == 32'h81000101, "single_beat3", 64'(cur_pkt[3]), 64'h81000101);
      check(cur_pkt[4] == 32'h0800a0a1, "single_beat4", 64'(cur_pkt[4]), 64'h0800a0a1);
`else
      check(last_pkt_beats == 17, "single_nbeats", 64'(last_pkt_beats), 64'd17);
      check(cur_pkt[3] == 32'h0800a0a1, "single_beat3", 64'(cur_pkt[3]), 64'h0800a0a1);
      check(cur_pkt[4] == 32'ha2a3a4a5, "single_beat4", 64'(cur_pkt[4]), 64'ha2a3a4a5);
`endif
      check(cur_pkt[0] == 32'haabbccdd, "single_beat0", 64'(cur_pkt[0]), 64'haabbccdd);
      check(last_keep == 4'b1000, "single_last_keep", 64'(last_keep), 64'h8);
      check(cur_pkt[last_pkt_beats-1] == 32'hd2000000, "single_last_data", 64'(cur_pkt[last_pkt_beats-1]), 64'hd2000000);

      // Sweep 64..73 back-to-back
      t_seed = 8'h3c;
      run_cfg(64, 1, 10, 0, 10);
      wait_done(1000, "sweep");
      end_checks("sweep", 10);

      // Same sweep under random backpressure; a mid-run Start must be ignored
      rand_ready = 1;
      run_cfg(64, 1, 10, 0, 10);
      repeat (20) @(posedge SysClk);
      #1 Start = 1'b1;
      @(posedge SysClk); #1 Start = 1'b0;
      wait_done(4000, "bp");
      end_checks("bp", 10);
      rand_ready = 0;

      // Gap of 3 idle cycles
      t_seed = 8'hfe;
      run_cfg(20, 0, 4, 3, 4);
      wait_done(1000, "gap3");
      end_checks("gap3", 4);

      // Continuous run stopped during beat 5 of packet 2
      t_seed = 8'h11; t_vid = 12'habc; t_pri = 3'd5;
      run_cfg(40, 0, 0, 0, 2);
      wait_beat(1, 5, "stop_reach_beat5");
      @(posedge SysClk); #1 Stop = 1'b1;
      @(posedge SysClk); #1 Stop = 1'b0;
      wait_done(400, "stop");
      end_checks("stop", 2);

      // Start with Stop in IDLE: no run begins, PktCnt retained
      @(posedge SysClk); #1;
      CfgPktNum = 16'd1; CfgPayLen = 16'd10; Start = 1'b1; Stop = 1'b1;
      @(posedge SysClk); #1 Start = 1'b0; Stop = 1'b0;
      @(negedge SysClk);
      check(!Busy && !TxValid && DbgState == 2'd0, "startstop_idle", 64'({Busy, TxValid, DbgState}), 64'd0);
      @(negedge SysClk);
      check(PktCnt == CNT_W'(2) && !TxValid, "startstop_pktcnt", 64'(PktCnt), 64'd2);

      // Length wrap at MAX_LEN = 100: 98, 100, 98
      t_seed = 8'h00;
      run_cfg(98, 2, 3, 1, 3);
      wait_done(1000, "wrap");
      end_checks("wrap", 3);

      // Asynchronous reset in the middle of a packet
      run_cfg(40, 0, 0, 0, 1);
      wait_beat(0, 3, "rst_reach_beat3");
      @(posedge SysClk); #3 Rst = 1'b1;
      exp_q.delete(); gap_q.delete();
      #1;
      check({TxValid, TxSop, TxEop, Busy, Done} == 5'd0, "midrst_ctrl", 64'({TxValid, TxSop, TxEop, Busy, Done}), 64'd0);
      check(TxData == '0 && TxKeep == '0, "midrst_data", 64'({TxKeep, TxData}), 64'd0);
      check(PktCnt == '0 && DbgState == 2'd0, "midrst_cnt_state", 64'({PktCnt, DbgState}), 64'd0);
      repeat (2) @(posedge SysClk);
      #1 Rst = 1'b0;
      any_valid = 0;
      for (c = 0; c < 10; c++) begin
         @(negedge SysClk);
         if (TxValid || Busy) any_valid = 1;
      end
      check(!any_valid, "no_recovery_frame", 64'(any_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eth_pkt_gen.md
# eth_pkt_gen

Synthesizable, parametrised Ethernet test-packet generator. It emits a stream of (optionally VLAN-tagged) Ethernet frames with a configurable header, a payload-length sweep, an inter-packet gap and backpressure support. It sits in front of the switch-core RX lanes (RapidIO / 10G AXI-stream paths) as an in-fabric traffic source for bring-up and loopback, and it generalises the bench-only 32-bit generator to any byte-multiple width.

## Interface
- DATA_W, 32, stream width in bits; multiple of 8, range 32..128; BYTES = DATA_W/8.
- MAX_LEN, 9000, maximum payload bytes; the sweep wraps above this.
- CNT_W, 32, width of the sent-packet counter.
- SysClk  in  1  sole clock.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; latches all Cfg* inputs and begins a run.
- Stop  in  1  pulse; requests a graceful end of the run.
- CfgDstMac / CfgSrcMac  in  48 each  header MAC addresses.
- CfgVlanId  in  12  VID; CfgVlanPri  in  3  PCP (only with the VLAN macro).
- CfgEthType  in  16  EtherType/length field.
- CfgPayLen  in  16  first-packet payload bytes; 0 is treated as 1.
- CfgLenStep  in  16  payload increment per packet.
- CfgPktNum  in  16  packets per run; 0 means continuous.
- CfgGap  in  16  idle cycles between packets.
- CfgSeed  in  8  first payload byte.
- TxReady  in  1  sink ready.
- TxValid, TxSop, TxEop  out  1  beat qualifiers.
- TxData  out  DATA_W  byte 0 of each beat in [DATA_W-1 -: 8] (network order).
- TxKeep  out  BYTES  byte enables, MSB = byte 0.
- Busy  out  1  high while a run is active.
- Done  out  1  one-cycle pulse at the end of a run.
- PktCnt  out  CNT_W  packets accepted (count of Eop handshakes) in the current run.

## Operation
- Frame bytes: Dst(6), Src(6), optional tag {16'h8100, Pri, 1'b0, Vid}, EthType(2), payload.
- Payload byte k = (CfgSeed + k) mod 256, restarting at k = 0 in every packet.
- Header length H is 14, or 18 with the tag. Total = H + Len. Beats = ceil(Total/BYTES).
- Only the final beat may be partial. Its TxKeep is MSB-contiguous and its unused data bytes are 0.
- Payload length of packet i: Len(i) = Len(i-1) + CfgLenStep. If that exceeds MAX_LEN, the length restarts at the latched CfgPayLen.
- FSM states:
  - IDLE: Start → SEND.
  - SEND: on the Eop handshake, if the run is finished or a stop is pending → END; else if Gap > 0 → GAP; else → SEND (back-to-back).
  - GAP: counts Gap cycles → SEND. A pending Stop → END.
  - END: asserts Done for one cycle → IDLE.
- The run is finished when PktCnt reaches CfgPktNum (never finished when CfgPktNum is 0).
- Start is ignored unless the FSM is in IDLE. Start and Stop together in IDLE: Stop wins and no run begins.
- A Stop seen in SEND is held as pending. The current packet always completes (no truncated frames).
- Start clears PktCnt. PktCnt holds its value after the run ends.
- Cfg* inputs are used only at Start; later changes have no effect until the next Start.

## Timing
- Reset values: TxValid, TxSop, TxEop, Busy, Done = 0; TxData, TxKeep, PktCnt = 0; FSM = IDLE.
- Reset is asynchronous: asserting Rst mid-packet drops TxValid in the same instant. No recovery frame is sent.
- First TxValid/TxSop appears on the cycle after the Start pulse (latency 1).
- Handshake is AXI-stream: a beat transfers when TxValid && TxReady. While TxReady is low, TxValid and all data/qualifiers hold stable. TxValid never depends combinationally on TxReady.
- Gap = exactly CfgGap cycles with TxValid low between the Eop handshake and the next Sop.
- Done rises on the cycle after the final Eop handshake. Busy falls together with Done.
- A single-beat packet (Total ≤ BYTES) asserts TxSop and TxEop on the same beat.

## Configuration
- ETH_PKT_GEN_VLAN_EN
  - Defined: CfgVlanId/CfgVlanPri ports exist and every frame carries the 4-byte tag (H = 18).
  - Undefined: those ports and the tag logic are absent, and H = 14.

## Structure
- Package eth_pkt_gen_pkg holds:
  - the state enum (IDLE, SEND, GAP, END);
  - constants ETH_HDR_BYTES = 14, VLAN_TAG_BYTES = 4, VLAN_TPID = 16'h8100;
  - a function returning header byte n from the latched config.
- Sub-module eth_pkt_gen_beat: combinational beat builder. Inputs: byte offset, latched config, Total. Outputs: TxData and TxKeep for one beat.

## Test plan
All scenarios use DATA_W = 32 with the VLAN macro defined.
- Single packet: Dst aabbccddeeff, Src 112233445566, Vid 12'h101, Pri 0, EthType 0800, PayLen 51, PktNum 1, Ready = 1.
  - Expect 18 beats: beat0 = aabbccdd, beat3 = 81000101, beat4 = 0800_{seed, seed+1}.
  - Last beat has TxKeep 4'b1000. Done pulses one cycle after Eop. PktCnt = 1.
- Sweep: PayLen 64, LenStep 1, PktNum 10, Gap 0 → payload lengths 64..73, back-to-back Sop after each Eop. PktCnt = 10.
- Backpressure: same as the sweep, with TxReady driven randomly (~50% low) → accepted byte stream identical to the Ready = 1 run; TxValid/data stable during stalls.
- Gap 3: exactly 3 TxValid-low cycles between every packet pair.
- Stop mid-packet: PktNum 0, Stop at beat 5 of packet 2 → packet 2 completes with Eop, no further Sop. Done pulses and PktCnt = 2.
- Wrap and reset:
  - MAX_LEN = 100, PayLen 98, Step 2 → lengths 98, 100, 98.
  - Asserting Rst mid-beat → all outputs 0 immediately, FSM = IDLE.
